fft_sdiv_24s_8ns_16: RTL and testbench

- Iterative signed-by-unsigned divider: 24-bit signed dividend divided by 8-bit unsigned divisor, giving a 16-bit signed quotient and a 9-bit signed remainder.
- Inverse of the FFT datapath's 16s x 8ns -> 24 multiplier. Used to renormalise scaled butterfly products (e.g. divide-by-N in inverse FFT and block-scaling undo).
- Uses restoring long division on magnitudes, one quotient bit per cycle, with valid/ready handshakes on both sides.

---
 rtl/fft_sdiv_24s_8ns_16.sv | 162 ++++++++++++++++
 tb/tb_fft_sdiv_24s_8ns_16.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fft_sdiv_24s_8ns_16.sv
// Iterative signed-by-unsigned divider: restoring long division on magnitudes, one quotient
// bit per cycle, with sign fix-up, saturation and divide-by-zero handling.
module fft_sdiv_24s_8ns_16 #(
  parameter int unsigned din0_WIDTH = 24,
  parameter int unsigned din1_WIDTH = 8,
  parameter int unsigned dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH:0]   rem,
  output logic                  ovf,
  output logic                  div0
);

  localparam int unsigned AW = din0_WIDTH;
  localparam int unsigned BW = din1_WIDTH;
  localparam int unsigned QW = dout_WIDTH;
  localparam int unsigned RW = din1_WIDTH + 1;
  localparam int unsigned CW = $clog2(din0_WIDTH);

  localparam logic [AW-1:0] POS_LIM  = AW'((64'd1 << (QW - 1)) - 64'd1);
  localparam logic [AW-1:0] NEG_LIM  = AW'(64'd1 << (QW - 1));
  localparam logic [QW-1:0] QMAX     = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] QMIN     = {1'b1, {(QW-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(AW - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mag_q, mag_d;
  logic [RW-1:0] prem_q, prem_d;
  logic [BW-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic          dz_q, dz_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [QW-1:0] quot_q, quot_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          ovf_q, ovf_d;
  logic          div0_q, div0_d;
  logic [RW-1:0] sh_rem;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      prem_q      <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      prem_q      <= prem_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    prem_d  = prem_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;
    // Partial remainder never exceeds divisor-1, so its top bit is free to take the shift.
    sh_rem  = {prem_q[BW-1:0], mag_q[AW-1]};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_d   = din0[AW-1];
          mag_d   = din0[AW-1] ? AW'(AW'(0) - din0) : din0;
          dvsr_d  = din1;
          prem_d  = '0;
          cnt_d   = '0;
          dz_d    = (din1 == '0);
          state_d = (din1 == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        if (sh_rem >= {1'b0, dvsr_q}) begin
          prem_d = RW'(sh_rem - {1'b0, dvsr_q});
          mag_d  = {mag_q[AW-2:0], 1'b1};
        end else begin
          prem_d = sh_rem;
          mag_d  = {mag_q[AW-2:0], 1'b0};
        end
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        ovf_d  = 1'b0;
        div0_d = 1'b0;
        if (dz_q) begin
          quot_d = neg_q ? QMIN : QMAX;
          rem_d  = '0;
          div0_d = 1'b1;
        end else if (!neg_q && (mag_q > POS_LIM)) begin
          quot_d = QMAX;
          rem_d  = '0;
          ovf_d  = 1'b1;
        end else if (neg_q && (mag_q > NEG_LIM)) begin
          quot_d = QMIN;
          rem_d  = '0;
          ovf_d  = 1'b1;
        end else if (neg_q) begin
          quot_d = QW'(QW'(0) - mag_q[QW-1:0]);
          rem_d  = RW'(RW'(0) - prem_q);
        end else begin
          quot_d = mag_q[QW-1:0];
          rem_d  = prem_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_fft_sdiv_24s_8ns_16.sv
// Randomised self-checking bench for fft_sdiv_24s_8ns_16 against an integer-arithmetic model.
module tb_fft_sdiv_24s_8ns_16;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] din0 = '0;
  logic [7:0]  din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quot;
  logic [8:0]  rem;
  logic        ovf;
  logic        div0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ap_clk = ~ap_clk;

  fft_sdiv_24s_8ns_16 dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .ovf(ovf), .div0(div0)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer division (truncates toward zero), then saturate to 16 bits.
  task automatic model(input int a, input int b, output int q, output int r,
                       output int o, output int z);
    o = 0; z = 0;
    if (b == 0) begin
      z = 1; r = 0;
      q = (a < 0) ? -32768 : 32767;
    end else begin
      q = a / b;
      r = a % b;
      if (q > 32767)  begin q = 32767;  r = 0; o = 1; end
      if (q < -32768) begin q = -32768; r = 0; o = 1; end
    end
  endtask

  task automatic do_op(input int a, input int b, input int hold);
    int lat, eq, er, eo, ez, busy_rdy;
    logic [15:0] q0;
    logic [8:0]  r0;
    model(a, b, eq, er, eo, ez);
    @(negedge ap_clk);
    check("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1; din0 = 24'(a); din1 = 8'(b);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    lat = 0; busy_rdy = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) busy_rdy++;
      // A request while busy must be ignored.
      in_valid = (lat >= 3 && lat < 8);
      din0 = 24'($urandom); din1 = 8'($urandom);
      @(posedge ap_clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, (b == 0) ? 1 : 25);
    check("busy_in_ready", busy_rdy, 0);
    check("quot", int'($signed(quot)), eq);
    check("rem", int'($signed(rem)), er);
    check("ovf", int'(ovf), eo);
    check("div0", int'(div0), ez);
    q0 = quot; r0 = rem;
    for (int i = 0; i < hold; i++) begin
      @(posedge ap_clk); #1;
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_quot", int'(quot), int'(q0));
      check("hold_rem", int'(rem), int'(r0));
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    check("out_valid_clr", int'(out_valid), 0);
    check("in_ready_ret", int'(in_ready), 1);
  endtask

  initial begin
    int a, b;
    logic signed [23:0] t;

    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quot", int'(quot), 0);
    check("rst_rem", int'(rem), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_div0", int'(div0), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    do_op(1000, 7, 0);
    do_op(-1000, 7, 0);
    do_op(-6, 7, 0);
    do_op(8388607, 1, 0);
    do_op(-8388608, 255, 0);
    do_op(-32768, 1, 0);
    do_op(32767, 1, 0);
    do_op(32768, 1, 0);
    do_op(-32769, 1, 0);
    do_op(-5, 0, 0);
    do_op(5, 0, 0);
    do_op(0, 0, 0);
    do_op(123456, 200, 10);
    do_op(-777, 13, 0);

    // Reset while iterating: after edge 10 of CALC the count is 10.
    @(negedge ap_clk);
    in_valid = 1'b1; din0 = 24'(1000); din1 = 8'(7);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    #1 ap_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    do_op(1000, 7, 0);

    for (int i = 0; i < 60; i++) begin
      t = 24'($urandom);
      a = int'(t) >>> $urandom_range(0, 23);
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      do_op(a, b, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
